fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage directly upstream of the control unit.
// - Holds the PC and issues one request per instruction to instruction memory (variable latency).
// - Latches the returned word and splits it into opcode/rd/rs1/rs2.
// - Presents the fields to decode/CU with a valid/ready handshake; supports branch redirect with flush.
// PARAMETERS
// - ADDR_W   default 8        PC / imem address width
// - INSTR_W  default 16       instruction width; fields [15:12]=opcode [11:8]=rd [7:4]=rs1 [3:0]=rs2/imm
// - RESET_PC default 8'h00    PC value after reset
// PORTS
// - clk          in   1        clock, rising edge
// - rst_n        in   1        asynchronous active-low reset
// - imem_req     out  1        fetch request, one-cycle pulse
// - imem_addr    out  ADDR_W   fetch address, valid while imem_req=1
// - imem_rvalid  in   1        response valid, >=1 cycle after imem_req
// - imem_rdata   in   INSTR_W  response word, valid with imem_rvalid
// - redirect_en  in   1        branch/jump taken, single-cycle pulse
// - redirect_pc  in   ADDR_W   target PC, sampled with redirect_en
// - instr_valid  out  1        fields below hold a valid instruction
// - instr_ready  in   1        downstream (CU) accepts the instruction
// - opcode       out  4        IR[15:12], feeds the CU opcode input
// - rd, rs1, rs2 out  4 each   IR[11:8], IR[7:4], IR[3:0]
// - pc_out       out  ADDR_W   address of the presented instruction
// - illegal_op   out  1        instr_valid and opcode > 4'b0101
// BEHAVIOUR
// Reset (async, rst_n=0):
// - state=REQ, pc=RESET_PC.
// - imem_req=0, instr_valid=0, IR=0, pc_out=0, illegal_op=0.
// - First imem_req is issued in the first cycle after rst_n deasserts.
// - Reset mid-fetch: the outstanding response is forgotten; no drain.
// States (all outputs registered):
// - REQ: imem_req=1, imem_addr=pc for exactly this cycle; next=WAIT.
// - WAIT: on imem_rvalid:
//   - IR<=imem_rdata, pc_out<=pc, pc<=pc+1 (mod 2^ADDR_W, 0xFF->0x00).
//   - instr_valid<=1; next=HOLD.
//   - Otherwise stay; no timeout.
// - HOLD: instr_valid=1; fields stay stable until handshake (instr_valid & instr_ready).
//   - On handshake: instr_valid<=0; next=REQ.
// - DRAIN: waiting to discard a stale response.
//   - On imem_rvalid: drop the data, next=REQ; IR and instr_valid unchanged (0).
// Throughput and latency:
// - Minimum 3 cycles per instruction: REQ, WAIT with rvalid, HOLD with ready.
// - rvalid -> instr_valid latency is 1 cycle.
// Redirect (highest priority, any state):
// - pc<=redirect_pc; instr_valid<=0 next cycle.
// - In REQ or WAIT (request outstanding): next=DRAIN.
// - In HOLD or DRAIN: next=REQ (HOLD) or stay DRAIN.
// - Redirect together with rvalid in WAIT: the response is stale; discard it, next=REQ.
// - Redirect together with a HOLD handshake: the handshake completes (CU consumed it); the redirect still applies.
// Other rules:
// - imem_rvalid outside WAIT/DRAIN is ignored.
// - imem_req is never high in two consecutive cycles.
// - At most one request is outstanding.
// TESTING
// - Reset release, imem latency 1, ready=1, words 16'h2123,16'h3456 -> opcode 2 then 3; pc_out 0,1; imem_req every 3rd cycle.
// - instr_ready low 5 cycles while instr_valid -> fields and pc_out stable, no new imem_req; handshake -> REQ next cycle.
// - redirect_en (pc=8'h40) during WAIT, imem latency 4 -> stale word never presented; next imem_addr=8'h40.
// - PC wrap: RESET_PC=8'hFF -> first pc_out 8'hFF, next fetch address 8'h00.
// - rdata 16'h7000 -> illegal_op=1 with instr_valid; 16'h5000 -> illegal_op=0.
// - rst_n low during WAIT, then late rvalid -> ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem request per instruction, latches the
// returned word and presents its fields to the control unit with valid/ready.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               illegal_op
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [ADDR_W-1:0]  PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]         OP_MAX    = 4'd5;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               illegal_q, illegal_d;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_MAX);
  endfunction

  // Next-state logic; redirect overrides every other event in every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    case (state_q)
      S_REQ: begin
        // REQ with no request out yet only occurs right after reset.
        if (!req_q) begin
          pc_d    = redirect_en ? redirect_pc : pc_q;
          state_d = S_REQ;
        end else if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + PC_ONE;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_REQ;
      end
    endcase
    req_d = (state_d == S_REQ);
    if (req_d) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end
    illegal_d = valid_d && is_illegal(ir_d[15:12]);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      ir_q      <= {INSTR_W{1'b0}};
      valid_q   <= 1'b0;
      pc_out_q  <= {ADDR_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      valid_q   <= valid_d;
      pc_out_q  <= pc_out_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = valid_q;
  assign opcode      = ir_q[15:12];
  assign rd          = ir_q[11:8];
  assign rs1         = ir_q[7:4];
  assign rs2         = ir_q[3:0];
  assign pc_out      = pc_out_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by randomized memory latency, back-pressure and
// redirects checked against a transaction-level reference model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_rvalid, redirect_en, instr_ready;
  logic [15:0] imem_rdata;
  logic [7:0]  redirect_pc;

  logic       imem_req, instr_valid, illegal_op;
  logic [7:0] imem_addr, pc_out;
  logic [3:0] opcode, rd, rs1, rs2;

  logic       w_req, w_valid, w_illegal;
  logic [7:0] w_addr, w_pc_out;
  logic [3:0] w_opcode, w_rd, w_rs1, w_rs2;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [256];
  logic        exp_valid, pending, resp_ok, prev_req, rv, rdy, redir;
  logic [7:0]  exp_addr, last_addr, rpc;
  int          cnt, hs;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc_out(pc_out), .illegal_op(illegal_op)
  );

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .instr_valid(w_valid), .instr_ready(instr_ready),
    .opcode(w_opcode), .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
    .pc_out(w_pc_out), .illegal_op(w_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    redirect_en = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    tick; tick;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_opcode", opcode, 4'h0);
    chk("rst_pc_out", pc_out, 8'h00);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_wrap_pc_out", w_pc_out, 8'h00);

    // Latency 1, always ready: one instruction every 3 cycles.
    rst_n = 1'b1; instr_ready = 1'b1;
    tick;
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 8'h00);
    chk("wrap_first_addr", w_addr, 8'hFF);
    tick;
    chk("wait_no_req", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 16'h2123;
    tick;
    imem_rvalid = 1'b0;
    chk("i0_valid", instr_valid, 1'b1);
    chk("i0_fields", {opcode, rd, rs1, rs2}, 16'h2123);
    chk("i0_pc_out", pc_out, 8'h00);
    chk("wrap_pc_out", w_pc_out, 8'hFF);
    chk("i0_no_req", imem_req, 1'b0);
    tick;
    chk("i0_consumed", instr_valid, 1'b0);
    chk("second_req", imem_req, 1'b1);
    chk("second_addr", imem_addr, 8'h01);
    chk("wrap_second_addr", w_addr, 8'h00);
    tick;
    chk("second_wait", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 16'h3456;
    tick;
    imem_rvalid = 1'b0;
    chk("i1_opcode", opcode, 4'h3);
    chk("i1_pc_out", pc_out, 8'h01);
    chk("i1_valid", instr_valid, 1'b1);
    tick;
    chk("third_req", imem_req, 1'b1);
    chk("third_addr", imem_addr, 8'h02);

    // Back-pressure with an illegal opcode held for 5 cycles.
    tick;
    imem_rvalid = 1'b1; imem_rdata = 16'h7000;
    tick;
    imem_rvalid = 1'b0;
    chk("ill_valid", instr_valid, 1'b1);
    chk("ill_flag", illegal_op, 1'b1);
    chk("ill_pc_out", pc_out, 8'h02);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_opcode", opcode, 4'h7);
      chk("stall_pc_out", pc_out, 8'h02);
      chk("stall_no_req", imem_req, 1'b0);
      chk("stall_illegal", illegal_op, 1'b1);
    end
    instr_ready = 1'b1;
    tick;
    chk("stall_release_valid", instr_valid, 1'b0);
    chk("stall_release_req", imem_req, 1'b1);
    chk("stall_release_addr", imem_addr, 8'h03);
    tick;
    imem_rvalid = 1'b1; imem_rdata = 16'h5000;
    tick;
    imem_rvalid = 1'b0;
    chk("op5_valid", instr_valid, 1'b1);
    chk("op5_opcode", opcode, 4'h5);
    chk("op5_legal", illegal_op, 1'b0);
    tick;
    chk("fifth_req", imem_req, 1'b1);
    chk("fifth_addr", imem_addr, 8'h04);

    // Redirect during WAIT with a 4-cycle memory: stale word dropped.
    tick;
    redirect_en = 1'b1; redirect_pc = 8'h40;
    tick;
    redirect_en = 1'b0;
    chk("drain_valid", instr_valid, 1'b0);
    chk("drain_req", imem_req, 1'b0);
    tick;
    chk("drain_valid2", instr_valid, 1'b0);
    chk("drain_req2", imem_req, 1'b0);
    tick;
    chk("drain_req3", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 16'h1111;
    tick;
    imem_rvalid = 1'b0;
    chk("stale_dropped", instr_valid, 1'b0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 8'h40);
    tick;
    imem_rvalid = 1'b1; imem_rdata = 16'h4ABC;
    tick;
    imem_rvalid = 1'b0;
    chk("redir_valid", instr_valid, 1'b1);
    chk("redir_pc_out", pc_out, 8'h40);
    chk("redir_opcode", opcode, 4'h4);
    tick;
    chk("post_redir_addr", imem_addr, 8'h41);

    // Reset while waiting; a late response right after release is ignored.
    tick;
    rst_n = 1'b0;
    tick;
    chk("mid_rst_valid", instr_valid, 1'b0);
    chk("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_pc_out", pc_out, 8'h00);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 16'h6FFF;
    tick;
    imem_rvalid = 1'b0;
    chk("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 8'h00);
    chk("late_ignored", instr_valid, 1'b0);
    tick;
    imem_rvalid = 1'b1; imem_rdata = 16'h0123;
    tick;
    imem_rvalid = 1'b0;
    chk("restart_valid", instr_valid, 1'b1);
    chk("restart_fields", {opcode, rd, rs1, rs2}, 16'h0123);
    chk("restart_pc_out", pc_out, 8'h00);

    // Randomized phase against the reference model.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0; instr_ready = 1'b0; redirect_en = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_valid = 1'b0; pending = 1'b0; resp_ok = 1'b0; prev_req = 1'b0;
    exp_addr = 8'h00; last_addr = 8'h00; cnt = 0; hs = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      rv = 1'b0;
      if (pending && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          rv = 1'b1;
          pending = 1'b0;
        end
      end
      chk("r_valid", instr_valid, exp_valid);
      chk("r_illegal", illegal_op, exp_valid && (mem[last_addr][15:12] > 4'd5));
      chk("r_req_busy", imem_req && (pending || prev_req || exp_valid), 1'b0);
      if (exp_valid) begin
        chk("r_fields", {opcode, rd, rs1, rs2}, mem[last_addr]);
        chk("r_pc_out", pc_out, last_addr);
      end
      if (imem_req) begin
        chk("r_req_addr", imem_addr, exp_addr);
        pending = 1'b1; resp_ok = 1'b1;
        cnt = $urandom_range(1, 4);
        last_addr = exp_addr;
      end
      prev_req = imem_req;

      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = 8'($urandom);
      instr_ready = rdy; redirect_en = redir; redirect_pc = rpc;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem[last_addr] : 16'($urandom);
      if (redir) begin
        exp_valid = 1'b0; exp_addr = rpc; resp_ok = 1'b0;
      end else if (exp_valid && rdy) begin
        exp_valid = 1'b0; exp_addr = last_addr + 8'd1; hs++;
      end else if (rv && resp_ok) begin
        exp_valid = 1'b1;
      end
    end
    chk("r_progress", (hs >= 50), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
